div_sys_mem_tester: RTL and testbench

- Avalon-MM master that exercises the on-chip memory slave: writes a deterministic pattern over a word range, then reads it back and compares.
- Sits beside the CPU in div_sys. Its master port connects through the interconnect to the memory's second slave port, so RAM can be self-tested at boot without the processor.
- Reports completion, pass/fail, error count and first failing address.

---
 rtl/div_sys_mem_tester_if.sv | 43 ++++
 rtl/div_sys_mem_tester.sv | 186 ++++++++++++++++++
 tb/tb_div_sys_mem_tester.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_sys_mem_tester_if.sv
// Avalon-MM bundle between the boot-time memory tester (master) and the RAM's second slave port.
interface div_sys_mem_tester_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  // Handshake: a request (avm_read or avm_write, with avm_chipselect) is accepted on a
  // rising edge where it is asserted and avm_waitrequest is low; until that edge the
  // master holds read/write, address and writedata stable. Read data returns on a later
  // cycle qualified by avm_readdatavalid, one beat per accepted read.
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_chipselect;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic                avm_waitrequest;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_byteenable,
    output avm_chipselect,
    output avm_read,
    output avm_write,
    output avm_writedata,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_byteenable,
    input  avm_chipselect,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/div_sys_mem_tester.sv
// Boot-time RAM self-test master: writes seed-based pattern over a word range,
// reads it back one outstanding read at a time, and reports pass/fail statistics.
module div_sys_mem_tester #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [CNT_W-1:0]     length,
  input  logic [DATA_W-1:0]    seed,
  input  logic                 invert,
  div_sys_mem_tester_if.master avm,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              inv_q, inv_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic              pass_q, pass_d;

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] pat_sum;
  logic [DATA_W-1:0] pattern;
  logic              last_beat;
  logic              req_wr;
  logic              req_rd;
  logic              accept;
  logic              mismatch;

  // Address and pattern both derive from the word index, so wrap-around is free.
  always_comb begin
    cur_addr  = base_q + ADDR_W'(idx_q);
    pat_sum   = seed_q + DATA_W'(idx_q);
    pattern   = inv_q ? ~pat_sum : pat_sum;
    last_beat = (idx_q == (len_q - CNT_W'(1)));
    req_wr    = (state_q == S_WRITE);
    req_rd    = (state_q == S_RD_REQ);
    accept    = !avm.avm_waitrequest;
    mismatch  = (avm.avm_readdata != pattern);
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    seed_d  = seed_q;
    inv_d   = inv_q;
    idx_d   = idx_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base_addr;
          len_d  = length;
          seed_d = seed;
          inv_d  = invert;
          idx_d  = '0;
          err_d  = '0;
          ferr_d = '0;
          pass_d = 1'b0;
          if (length == '0) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = S_WRITE;
          end
        end
      end

      // abort is only honoured once the current write beat has been accepted.
      S_WRITE: begin
        if (accept) begin
          if (abort) begin
            state_d = S_DONE;
            pass_d  = 1'b0;
          end else if (last_beat) begin
            idx_d   = '0;
            state_d = S_RD_REQ;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end

      S_RD_REQ: begin
        if (accept) begin
          state_d = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (avm.avm_readdatavalid) begin
          if (mismatch) begin
            if (err_q != '1) begin
              err_d = err_q + CNT_W'(1);
            end
            if (err_q == '0) begin
              ferr_d = cur_addr;
            end
          end
          if (abort || last_beat) begin
            state_d = S_DONE;
            pass_d  = !abort && (err_d == '0);
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = S_RD_REQ;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      inv_q   <= 1'b0;
      idx_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      inv_q   <= inv_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      pass_q  <= pass_d;
    end
  end

  // Bus outputs are pure functions of registered state, so they stay stable under stalls.
  assign avm.avm_write      = req_wr;
  assign avm.avm_read       = req_rd;
  assign avm.avm_chipselect = req_wr | req_rd;
  assign avm.avm_address    = (req_wr | req_rd) ? cur_addr : '0;
  assign avm.avm_writedata  = req_wr ? pattern : '0;
  assign avm.avm_byteenable = '1;

  assign busy           = (state_q == S_WRITE) || (state_q == S_RD_REQ) ||
                          (state_q == S_RD_WAIT);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_div_sys_mem_tester.sv
// Randomized scoreboard bench for div_sys_mem_tester with a stalling, optionally corrupting RAM model.
`timescale 1ns/1ps
module tb_div_sys_mem_tester;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int BE_W   = DATA_W / 8;
  localparam int WR_W   = 2 + BE_W + ADDR_W + DATA_W;
  localparam int RD_W   = 2 + BE_W + ADDR_W;
  localparam int RES_W  = 1 + CNT_W + ADDR_W;
  localparam int REQ_W  = 2 + ADDR_W + DATA_W;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  length = '0;
  logic [DATA_W-1:0] seed = '0;
  logic              invert = 1'b0;
  logic              busy, done, pass;
  logic [CNT_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [2:0]        dbg_state;

  div_sys_mem_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  div_sys_mem_tester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .base_addr      (base_addr),
    .length         (length),
    .seed           (seed),
    .invert         (invert),
    .avm            (bus),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [WR_W-1:0]  exp_wr_q[$];
  logic [RD_W-1:0]  exp_rd_q[$];
  logic [RES_W-1:0] exp_res_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0;
  int n_rd = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int                wait_pct = 0;
  logic              corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  logic              acc_wr = 1'b0;
  logic              acc_rd = 1'b0;
  logic [ADDR_W-1:0] acc_addr = '0;
  logic [DATA_W-1:0] acc_data = '0;

  initial begin
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset_n) begin
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
      end else begin
        if (acc_wr) mem[acc_addr] = acc_data;
        if (acc_rd) begin
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata      = mem[acc_addr];
          if (corrupt_en && acc_addr == corrupt_addr)
            bus.avm_readdata = bus.avm_readdata ^ DATA_W'(1);
        end else begin
          bus.avm_readdatavalid = 1'b0;
          bus.avm_readdata      = DATA_W'($urandom);
        end
      end
      bus.avm_waitrequest = ($urandom_range(1, 100) <= wait_pct);
    end
  end

  // ---------------- monitor: accepts beats, pops and compares ----------------
  logic              stall_prev = 1'b0;
  logic [REQ_W-1:0]  prev_req = '0;
  logic [WR_W-1:0]   e_wr;
  logic [RD_W-1:0]   e_rd;
  logic [RES_W-1:0]  e_res;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        acc_wr     = 1'b0;
        acc_rd     = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          check("stall_hold",
                64'({bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata}),
                64'(prev_req));
        acc_wr     = bus.avm_write && !bus.avm_waitrequest;
        acc_rd     = bus.avm_read && !bus.avm_waitrequest;
        acc_addr   = bus.avm_address;
        acc_data   = bus.avm_writedata;
        prev_req   = {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata};
        stall_prev = (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
        if (acc_wr) begin
          n_wr++;
          e_wr = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : 'x;
          check("write_beat",
                64'({bus.avm_chipselect, bus.avm_read, bus.avm_byteenable,
                     bus.avm_address, bus.avm_writedata}), 64'(e_wr));
        end
        if (acc_rd) begin
          n_rd++;
          e_rd = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 'x;
          check("read_beat",
                64'({bus.avm_chipselect, bus.avm_write, bus.avm_byteenable, bus.avm_address}),
                64'(e_rd));
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          e_res = (exp_res_q.size() > 0) ? exp_res_q.pop_front() : 'x;
          check("done_result", 64'({pass, err_count, first_err_addr}), 64'(e_res));
          check("done_bus_idle",
                64'({bus.avm_chipselect, bus.avm_read, bus.avm_write, busy}), 64'(0));
        end
      end
    end
  end

  // ---------------- reference model + driver ----------------
  task automatic wait_done(input int d0, input int budget);
    int k;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("done_seen", 64'(done_cnt - d0), 64'(1));
  endtask

  task automatic run_test(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n,
                          input logic [DATA_W-1:0] s, input logic inv, input int pct,
                          input logic cen, input logic [ADDR_W-1:0] ca,
                          input int exp_lat, input logic abort_at_start);
    int                errs, wr0, rd0, d0, t0;
    logic [ADDR_W-1:0] a, ferr;
    logic [DATA_W-1:0] d;
    logic [RES_W-1:0]  res;
    errs = 0;
    ferr = '0;
    wait_pct     = pct;
    corrupt_en   = cen;
    corrupt_addr = ca;
    for (int i = 0; i < int'(n); i++) begin
      a = ADDR_W'((int'(b) + i) % (1 << ADDR_W));
      d = s + DATA_W'(i);
      if (inv) d = ~d;
      exp_wr_q.push_back({1'b1, 1'b0, {BE_W{1'b1}}, a, d});
      exp_rd_q.push_back({1'b1, 1'b0, {BE_W{1'b1}}, a});
      if (cen && a == ca) begin
        if (errs == 0) ferr = a;
        errs++;
      end
    end
    res = {(errs == 0), CNT_W'(errs), ferr};
    exp_res_q.push_back(res);

    wr0 = n_wr;
    rd0 = n_rd;
    d0  = done_cnt;
    t0  = cyc;
    base_addr = b;
    length    = n;
    seed      = s;
    invert    = inv;
    start     = 1'b1;
    abort     = abort_at_start;
    @(posedge clk);
    #1;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = ADDR_W'($urandom);
    length    = CNT_W'($urandom);
    seed      = DATA_W'($urandom);
    invert    = ~inv;
    wait_done(d0, 40 * int'(n) + 50);
    if (exp_lat >= 0) check("latency", 64'(done_cyc - t0), 64'(exp_lat));
    check("write_count", 64'(n_wr - wr0), 64'(n));
    check("read_count", 64'(n_rd - rd0), 64'(n));
    check("result_hold", 64'({pass, err_count, first_err_addr}), 64'(res));
    check("queues_drained", 64'(exp_wr_q.size() + exp_rd_q.size() + exp_res_q.size()), 64'(0));
  endtask

  // Abort raised while the third write is stalled; a second start mid-test must be ignored.
  task automatic abort_test();
    int                wr0, rd0, d0;
    logic [ADDR_W-1:0] b;
    logic [DATA_W-1:0] s;
    b = 15'h0040;
    s = DATA_W'($urandom);
    wait_pct = 0;
    corrupt_en = 1'b0;
    for (int i = 0; i < 3; i++)
      exp_wr_q.push_back({1'b1, 1'b0, {BE_W{1'b1}}, b + ADDR_W'(i), s + DATA_W'(i)});
    exp_res_q.push_back('0);
    wr0 = n_wr;
    rd0 = n_rd;
    d0  = done_cnt;
    base_addr = b;
    length    = CNT_W'(8);
    seed      = s;
    invert    = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    wait_pct = 100;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("busy_while_stalled", 64'(busy), 64'(1));
    abort     = 1'b1;
    start     = 1'b1;
    base_addr = 15'h1234;
    @(posedge clk);
    #1;
    start    = 1'b0;
    wait_pct = 0;
    wait_done(d0, 50);
    abort = 1'b0;
    check("abort_write_count", 64'(n_wr - wr0), 64'(3));
    check("abort_read_count", 64'(n_rd - rd0), 64'(0));
    check("abort_pass", 64'(pass), 64'(0));
    check("abort_queues", 64'(exp_wr_q.size() + exp_res_q.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_status"},
          64'({busy, done, pass, err_count, first_err_addr, dbg_state}), 64'(0));
    check({tag, "_bus"},
          64'({bus.avm_chipselect, bus.avm_read, bus.avm_write,
               bus.avm_address, bus.avm_writedata}), 64'(0));
    check({tag, "_byteenable"}, 64'(bus.avm_byteenable), 64'({BE_W{1'b1}}));
  endtask

  task automatic reset_mid_read();
    int rd0, k;
    wait_pct = 0;
    corrupt_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_wr_q.push_back({1'b1, 1'b0, {BE_W{1'b1}}, 15'h0200 + ADDR_W'(i), 32'h5000 + DATA_W'(i)});
      exp_rd_q.push_back({1'b1, 1'b0, {BE_W{1'b1}}, 15'h0200 + ADDR_W'(i)});
    end
    rd0 = n_rd;
    base_addr = 15'h0200;
    length    = CNT_W'(8);
    seed      = 32'h5000;
    invert    = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (n_rd - rd0 < 2 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("reads_before_reset", 64'(n_rd - rd0), 64'(2));
    check("busy_before_reset", 64'(busy), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_res_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [ADDR_W-1:0] rb, rca;
    logic [CNT_W-1:0]  rn;
    int                rpct;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_test(15'h0000, 16'd4, 32'h10, 1'b0, 0, 1'b0, '0, 13, 1'b0);
    run_test(15'h0100, 16'd8, DATA_W'($urandom), 1'b0, 0, 1'b1, 15'h0102, 25, 1'b0);
    run_test(15'h7ffe, 16'd4, 32'h0, 1'b1, 0, 1'b0, '0, 13, 1'b0);
    run_test(ADDR_W'($urandom), 16'd16, DATA_W'($urandom), 1'b0, 50, 1'b0, '0, -1, 1'b0);
    run_test(15'h0010, 16'd0, 32'h1, 1'b0, 0, 1'b0, '0, 1, 1'b0);
    run_test(15'h0020, 16'd3, 32'hffff_fffe, 1'b0, 0, 1'b0, '0, 10, 1'b1);
    abort_test();

    for (int t = 0; t < 10; t++) begin
      rb   = ADDR_W'($urandom);
      rn   = CNT_W'($urandom_range(1, 24));
      rpct = ($urandom_range(0, 1) == 1) ? 50 : 0;
      rca  = ($urandom_range(0, 1) == 1) ? rb + ADDR_W'($urandom_range(0, int'(rn) - 1))
                                          : ADDR_W'($urandom);
      run_test(rb, rn, DATA_W'($urandom), 1'($urandom_range(0, 1)), rpct,
               1'($urandom_range(0, 1)), rca, (rpct == 0) ? 3 * int'(rn) + 1 : -1, 1'b0);
    end

    reset_mid_read();
    run_test(15'h0300, 16'd5, 32'habcd_0000, 1'b1, 0, 1'b0, '0, 16, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
